// File: rtl/irq_conditioner_if.sv
// Configuration write bus plus raw and conditioned interrupt lines for irq_conditioner.
interface irq_conditioner_if #(
  parameter int N_INTS = 9
) ();
  logic              en;
  logic [4:0]        address;
  logic [31:0]       din;
  logic [N_INTS-1:0] irq_raw;
  logic [N_INTS-1:0] interrupts;
  logic              active;

  modport master (
    output en, address, din, irq_raw,
    input  interrupts, active
  );

  modport slave (
    input  en, address, din, irq_raw,
    output interrupts, active
  );
endinterface

// File: rtl/irq_conditioner.sv
// irq_conditioner: synchronise, polarity-correct and glitch-filter interrupt lines.
// Latency SYNC_STAGES+L edges per level change; no backpressure, outputs are plain levels.
module irq_conditioner #(
  parameter int N_INTS      = 9,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_WIDTH  = 4,
  parameter int FILT_RESET  = 3
) (
  input  logic               i_clk,
  input  logic               i_arst,
  irq_conditioner_if.slave   bus
);

  localparam logic [4:0] ADDR_POLARITY = 5'd16;
  localparam logic [4:0] ADDR_FILTER   = 5'd17;

  logic [N_INTS-1:0]     sync_q [SYNC_STAGES];
  logic [N_INTS-1:0]     pol_q;
  logic [N_INTS-1:0]     stable_q;
  logic [N_INTS-1:0]     stable_d;
  logic [FILT_WIDTH-1:0] cnt_q  [N_INTS];
  logic [FILT_WIDTH-1:0] cnt_d  [N_INTS];
  logic [FILT_WIDTH-1:0] filt_len_q;
  logic [FILT_WIDTH-1:0] eff_len;
  logic                  active_q;

  logic                  wr_pol;
  logic                  wr_filt;
  logic [N_INTS-1:0]     pol_new;
  logic [N_INTS-1:0]     pol_chg;
  logic [N_INTS-1:0]     lvl;
  logic                  unused_din;

  assign wr_pol     = bus.en && (bus.address == ADDR_POLARITY);
  assign wr_filt    = bus.en && (bus.address == ADDR_FILTER);
  assign pol_new    = bus.din[N_INTS-1:0];
  assign pol_chg    = wr_pol ? (pol_q ^ pol_new) : '0;
  assign lvl        = sync_q[SYNC_STAGES-1] ^ pol_q;
  assign eff_len    = (filt_len_q == '0) ? FILT_WIDTH'(1) : filt_len_q;
  assign unused_din = ^bus.din;

  // Config writes override any terminal count landing on the same edge.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_INTS; i++) begin
      cnt_d[i] = '0;
      if (lvl[i] != stable_q[i]) begin
        if (cnt_q[i] == eff_len - FILT_WIDTH'(1)) begin
          stable_d[i] = lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + FILT_WIDTH'(1);
        end
      end
      if (wr_filt) begin
        cnt_d[i]    = '0;
        stable_d[i] = stable_q[i];
      end
      if (pol_chg[i]) begin
        cnt_d[i]    = '0;
        stable_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < N_INTS; i++) begin
        cnt_q[i] <= '0;
      end
      pol_q      <= '0;
      filt_len_q <= FILT_WIDTH'(FILT_RESET);
      stable_q   <= '0;
      active_q   <= 1'b0;
    end else begin
      sync_q[0] <= bus.irq_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < N_INTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (wr_pol) begin
        pol_q <= pol_new;
      end
      if (wr_filt) begin
        filt_len_q <= bus.din[FILT_WIDTH-1:0];
      end
      stable_q <= stable_d;
      active_q <= |stable_d;
    end
  end

  assign bus.interrupts = stable_q;
  assign bus.active     = active_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Randomised and directed scoreboard bench for irq_conditioner against a run-length reference model.
module tb_irq_conditioner;
  localparam int N  = 9;
  localparam int SS = 2;

  typedef struct packed {
    logic [N-1:0] irq;
    logic         act;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  irq_conditioner_if #(.N_INTS(N)) bus ();

  irq_conditioner #(.N_INTS(N), .SYNC_STAGES(SS), .FILT_WIDTH(4), .FILT_RESET(3)) dut (
    .i_clk (clk),
    .i_arst(rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a delay line of raw samples and, per line, the length of
  // the current run of corrected samples that disagree with the output level.
  logic [N-1:0] m_dly [SS];
  logic [N-1:0] m_pol;
  logic [N-1:0] m_out;
  int           m_flen;
  int           m_run [N];
  exp_t         exp_q [$];

  function automatic void model_reset();
    for (int k = 0; k < SS; k++) m_dly[k] = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_pol  = '0;
    m_out  = '0;
    m_flen = 3;
  endfunction

  function automatic void model_step(input logic [N-1:0] raw, input logic en,
                                     input logic [4:0] addr, input logic [31:0] din);
    int           need;
    logic [N-1:0] seen;
    logic [N-1:0] nxt;
    exp_t         e;
    need = (m_flen == 0) ? 1 : m_flen;
    seen = m_dly[SS-1] ^ m_pol;
    nxt  = m_out;
    for (int i = 0; i < N; i++) begin
      if (seen[i] != m_out[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= need) begin
          nxt[i]   = seen[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (en && addr == 5'd17) begin
      for (int i = 0; i < N; i++) m_run[i] = 0;
      nxt    = m_out;
      m_flen = int'(din[3:0]);
    end
    if (en && addr == 5'd16) begin
      for (int i = 0; i < N; i++) begin
        if (din[i] != m_pol[i]) begin
          m_run[i] = 0;
          nxt[i]   = 1'b0;
        end
      end
      m_pol = din[N-1:0];
    end
    m_out = nxt;
    for (int k = SS - 1; k > 0; k--) m_dly[k] = m_dly[k-1];
    m_dly[0] = raw;
    e.irq = nxt;
    e.act = |nxt;
    exp_q.push_back(e);
  endfunction

  // Monitor: outputs are levels, so every active edge presents one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.interrupts !== e.irq || bus.active !== e.act) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d got irq=%h act=%b expected irq=%h act=%b",
                   cyc, bus.interrupts, bus.active, e.irq, e.act);
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic step(input logic [N-1:0] raw, input logic en,
                      input logic [4:0] addr, input logic [31:0] din);
    @(negedge clk);
    bus.irq_raw = raw;
    bus.en      = en;
    bus.address = addr;
    bus.din     = din;
    model_step(raw, en, addr, din);
  endtask

  task automatic idle(input logic [N-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic observe(output logic [N-1:0] o, output logic a);
    @(posedge clk);
    #2;
    o = bus.interrupts;
    a = bus.active;
  endtask

  // Edge index (sampling edge = 1) at which the given line first reads high.
  task automatic measure(input logic [N-1:0] raw, input int line, input int maxk,
                         output int lat, output logic act);
    logic [N-1:0] o;
    logic         a;
    lat = -1;
    act = 1'b0;
    for (int k = 1; k <= maxk; k++) begin
      step(raw, 1'b0, 5'd0, 32'd0);
      observe(o, a);
      if (o[line] && lat < 0) begin
        lat = k;
        act = a;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.irq_raw = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int           lat;
    int           rise_k;
    int           fall_k;
    logic         act;
    logic         seen_hi;
    logic [N-1:0] o;
    logic         a;
    logic [N-1:0] raw;
    logic [4:0]   addr;
    logic [31:0]  din;

    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.address = '0;
    bus.din     = '0;
    bus.irq_raw = '0;
    model_reset();
    #3;
    chk("reset_interrupts", bus.interrupts, 0);
    chk("reset_active", bus.active, 0);
    do_reset();
    idle('0, 4);

    // Step on line 0 with the reset filter length.
    measure(9'h001, 0, 10, lat, act);
    chk("rise_latency_L3", lat, 5);
    chk("active_with_rise", act, 1);
    idle('0, 10);

    // Two-cycle pulse must be rejected.
    step(9'h004, 1'b0, 5'd0, 32'd0);
    step(9'h004, 1'b0, 5'd0, 32'd0);
    seen_hi = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step('0, 1'b0, 5'd0, 32'd0);
      observe(o, a);
      if (o[2]) seen_hi = 1'b1;
    end
    chk("short_pulse_rejected", seen_hi, 0);

    // Three-cycle pulse passes; fall follows release by the same latency.
    rise_k = -1;
    fall_k = -1;
    for (int k = 1; k <= 12; k++) begin
      step((k <= 3) ? 9'h004 : 9'h000, 1'b0, 5'd0, 32'd0);
      observe(o, a);
      if (o[2] && rise_k < 0) rise_k = k;
      if (!o[2] && rise_k > 0 && fall_k < 0) fall_k = k;
    end
    chk("pulse3_rise_edge", rise_k, 5);
    chk("pulse3_fall_edge", fall_k, 8);

    // Filter length 0 behaves as 1.
    step('0, 1'b1, 5'd17, 32'd0);
    idle('0, 4);
    measure(9'h010, 4, 6, lat, act);
    chk("rise_latency_L0", lat, 3);
    step(9'h010, 1'b1, 5'd17, 32'd3);
    idle('0, 8);

    // Polarity flip on line 0 while line 5 stays high.
    idle(9'h020, 8);
    step(9'h020, 1'b1, 5'd16, 32'h001);
    observe(o, a);
    chk("pol_write_line0", o[0], 0);
    chk("pol_write_line5_kept", o[5], 1);
    measure(9'h020, 0, 6, lat, act);
    chk("pol_line0_rise", lat, 3);
    step('0, 1'b1, 5'd16, 32'h000);
    idle('0, 8);

    // Fast toggling with filter length 2 never reaches the outputs.
    step('0, 1'b1, 5'd17, 32'd2);
    idle('0, 4);
    seen_hi = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step((k % 2) ? 9'h1FF : 9'h000, 1'b0, 5'd0, 32'd0);
      observe(o, a);
      if (o != '0 || a) seen_hi = 1'b1;
    end
    chk("toggle_rejected", seen_hi, 0);
    idle('0, 6);

    // Unmapped address must leave polarity and filter length alone.
    step('0, 1'b1, 5'd12, 32'hFFFF_FFFF);
    idle('0, 4);
    measure(9'h002, 1, 8, lat, act);
    chk("addr12_ignored_latency", lat, 4);

    // Asynchronous reset with outputs high and a count in progress.
    idle(9'h1FF, 8);
    step(9'h1F7, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_interrupts", bus.interrupts, 0);
    chk("async_reset_active", bus.active, 0);
    @(negedge clk);
    bus.en      = 1'b0;
    bus.irq_raw = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle('0, 4);
    measure(9'h001, 0, 10, lat, act);
    chk("post_reset_latency", lat, 5);
    idle('0, 10);

    // Randomised traffic with sparse config writes.
    raw = '0;
    for (int k = 0; k < 600; k++) begin
      raw = raw ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       addr = 5'd16;
          1:       addr = 5'd17;
          2:       addr = 5'd12;
          default: addr = 5'($urandom);
        endcase
        din = $urandom;
        if (addr == 5'd17) din = {28'd0, 4'($urandom_range(0, 5))};
        step(raw, 1'b1, addr, din);
      end else begin
        step(raw, 1'b0, 5'd0, 32'd0);
      end
    end
    idle(raw, 3);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
